cp0: RTL
========

Name: cp0

Overview:
- Coprocessor-0 for the P7 pipelined MIPS core.
- Issues the exception/interrupt entry request that the fetch-stage PC register consumes; the PC redirects to 0x0000_4180 while Req is high.
- Holds SR, Cause, EPC and PRId, and services mfc0, mtc0 and eret.
- Sits at the M stage and sees the victim instruction's PC, its delay-slot flag and its exception code.

Parameters:
- PRID, 32'h5059_4A5A, constant returned on reads of register 15.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset; 0 = reset asserted
- A  input  5  CP0 register number for mfc0/mtc0
- DIn  input  32  mtc0 write data
- WE  input  1  mtc0 write enable
- VPC  input  32  PC of the M-stage instruction
- BDIn  input  1  M-stage instruction is in a branch delay slot
- ExcCodeIn  input  5  pending exception code from the pipeline; 0 = none
- HWInt  input  6  external hardware interrupt lines, level-sensitive
- EXLClr  input  1  eret at M stage
- Req  output  1  exception/interrupt entry request to PC and pipeline flush
- EPCOut  output  32  current EPC, used by eret as the return target
- DOut  output  32  mfc0 read data

Behaviour:
- Registers and fields:
  - SR (12): IM[15:10], EXL[1], IE[0]; other bits read 0.
  - Cause (13): BD[31], IP[15:10], ExcCode[6:2]; other bits read 0.
  - EPC (14): 32 bits.
  - PRId (15): PRID parameter.
- Reset (reset==0, asynchronous): SR, Cause and EPC all clear to 0. Outputs during reset: Req=0, EPCOut=0, DOut follows A over the cleared registers.
- IntReq = reset & IE & ~EXL & |(HWInt & IM).
- ExcReq = reset & ~EXL & (ExcCodeIn != 0).
- Req = IntReq | ExcReq. Purely combinational, same cycle: the PC loads 0x4180 on the same edge that CP0 records the entry.
- Priority: interrupt over exception. If both are pending, ExcCode is 0 (Int) and the victim is still VPC.
- On a rising edge with Req=1:
  - EXL <= 1.
  - ExcCode <= IntReq ? 0 : ExcCodeIn.
  - BD <= BDIn.
  - EPC <= BDIn ? (VPC - 32'd4) : VPC. Arithmetic is modulo 2^32; EPC[1:0] is forced to 00 (VPC - 4 with VPC=0 wraps to 32'hFFFF_FFFC).
  - Any mtc0 write (WE) and any EXLClr in the same cycle are ignored.
- IP[15:10] <= HWInt on every rising edge when not in reset, regardless of Req or EXL.
- EXLClr=1 and Req=0: EXL <= 0 at the edge. IE and IM are unchanged.
- mtc0, applied only when WE & ~Req:
  - A=12: IM, EXL and IE are taken from DIn; other bits are discarded.
  - A=14: EPC <= {DIn[31:2], 2'b00}.
  - A=13 and A=15: writes are ignored. Other addresses are ignored.
- WE to SR together with EXLClr in the same cycle: the mtc0 value is written first, then EXL is forced to 0.
- DOut is combinational from A: 12 gives SR, 13 gives Cause, 14 gives EPC, 15 gives PRID, any other address gives 0. DOut reflects register state before the current edge (no write bypass).
- EPCOut is the EPC register, without bypass. An mtc0 to EPC followed by eret relies on the pipeline's stall/forward logic.
- While EXL=1, all new interrupts and exceptions are masked and Req stays 0. Nested entry is not supported.
- Reset asserted mid-cycle clears all state immediately. Req drops without waiting for a clock edge.

Test Plan:
1. Reset then release; read A=12/13/14/15 -> DOut = 0, 0, 0, 32'h5059_4A5A; Req=0 with ExcCodeIn=0 and HWInt=0.
2. mtc0 A=12 DIn=32'h0000_0401 (IM[10]=1, IE=1); raise HWInt=6'b000001, VPC=32'h0000_3010, BDIn=0 -> Req=1 in that cycle. After the edge: EPC=32'h3010, Cause=32'h0000_0400 (IP[10]=1, ExcCode=0), SR=32'h0000_0403, and Req then drops to 0.
3. ExcCodeIn=5'd12 (Ov), BDIn=1, VPC=32'h0000_3024, IE=0 -> Req=1. After the edge: EPC=32'h3020, Cause=32'h8000_0030, EXL=1.
4. With EXL=1, ExcCodeIn=4 and HWInt enabled -> Req=0, EPC unchanged. Then EXLClr=1 for one cycle -> EXL=0, and the pending interrupt raises Req in the next cycle.
5. Interrupt and ExcCodeIn=10 in the same cycle, plus WE=1 with A=14, DIn=32'hDEAD_BEEF -> ExcCode=0, EPC=VPC (the write is ignored).
6. Pull reset low asynchronously while Req=1 between edges -> Req=0 immediately, and SR, Cause and EPC are all 0 without a clock edge.

Source files
------------

// File: rtl/cp0.sv
// Coprocessor-0: SR/Cause/EPC/PRId, exception/interrupt entry request, mfc0/mtc0/eret.
// Entry request is combinational so the PC and CP0 both commit the entry on the same edge.
module cp0 #(
    parameter logic [31:0] PRID = 32'h5059_4A5A
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        Req,
    output logic [31:0] EPCOut,
    output logic [31:0] DOut
);

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] victim_pc;
    logic        int_req, exc_req;

    assign int_req = reset & ie_q & ~exl_q & (|(HWInt & im_q));
    assign exc_req = reset & ~exl_q & (ExcCodeIn != 5'd0);
    assign Req     = int_req | exc_req;

    assign victim_pc = BDIn ? (VPC - 32'd4) : VPC;

    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ip_d       = HWInt;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        if (Req) begin
            exl_d      = 1'b1;
            exc_code_d = int_req ? 5'd0 : ExcCodeIn;
            bd_d       = BDIn;
            epc_d      = {victim_pc[31:2], 2'b00};
        end else begin
            if (WE && A == 5'd12) begin
                im_d  = DIn[15:10];
                exl_d = DIn[1];
                ie_d  = DIn[0];
            end
            if (WE && A == 5'd14)
                epc_d = {DIn[31:2], 2'b00};
            // eret wins over a same-cycle mtc0 to SR for the EXL bit
            if (EXLClr)
                exl_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im_q       <= 6'd0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_q       <= 6'd0;
            exc_code_q <= 5'd0;
            epc_q      <= 32'd0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ip_q       <= ip_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
        end
    end

    assign EPCOut = epc_q;

    always_comb begin
        DOut = 32'd0;
        case (A)
            5'd12:   DOut = {16'd0, im_q, 8'd0, exl_q, ie_q};
            5'd13:   DOut = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'b00};
            5'd14:   DOut = epc_q;
            5'd15:   DOut = PRID;
            default: DOut = 32'd0;
        endcase
    end

endmodule
